// File: rtl/line_sync_scheduler.sv
// line_sync_scheduler: aligns a first-word-fall-through pixel FIFO to the
// display line being scanned out. Stale words are dropped, words tagged
// for later lines are held back, and black fill covers any underrun.
module line_sync_scheduler #(
  parameter int unsigned VSTART     = 24,
  parameter int unsigned VFIN       = 745,
  parameter int unsigned HSTART     = 1,
  parameter int unsigned LINE_WORDS = 1200,
  parameter int unsigned HALF_WORDS = 600,
  parameter logic [15:0] FILL_PIX   = 16'h1080
) (
  input  logic        i_clk_74M,
  input  logic        i_rst,
  input  logic [11:0] i_vcnt,
  input  logic [11:0] i_hcnt,
  input  logic [28:0] src_data,
  input  logic        src_empty,
  output logic        src_rd,
  input  logic        disp_rd,
  output logic [28:0] o_data,
  output logic [1:0]  o_state,
  output logic [15:0] o_underrun_cnt,
  output logic [15:0] o_drop_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    STREAM = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [11:0] VSTART_V   = 12'(VSTART);
  localparam logic [11:0] VFIN_V     = 12'(VFIN);
  localparam logic [11:0] HSTART_H   = 12'(HSTART);
  localparam logic [10:0] LAST_WORD  = 11'(LINE_WORDS - 1);
  localparam logic [10:0] HALF_W     = 11'(HALF_WORDS);

  state_t      state;
  logic [10:0] target;
  logic [10:0] word_cnt;
  logic        rd_seen;
  logic [15:0] underrun_cnt;
  logic [15:0] drop_cnt;

  logic [10:0] diff;
  logic        head_match;
  logic        head_stale;
  logic        head_ahead;
  logic [28:0] fill_word;
  logic        line_start;
  logic        emit_fill;
  logic        line_done;

  // Head classification against the current target line (modulo 2048)
  always_comb begin
    diff       = src_data[26:16] - target;
    head_match = ~src_empty & (diff == '0);
    head_stale = ~src_empty & diff[10];
    head_ahead = ~src_empty & (diff != '0) & ~diff[10];
    fill_word  = {1'b0, (word_cnt >= HALF_W), target, FILL_PIX};
    line_start = (i_hcnt == '0) && (i_vcnt >= VSTART_V) && (i_vcnt < VFIN_V);
    line_done  = (disp_rd && (word_cnt == LAST_WORD)) || (rd_seen && !disp_rd);
  end

  // FIFO pop and display word, zero latency to match FWFT timing
  always_comb begin
    src_rd    = 1'b0;
    o_data    = fill_word;
    emit_fill = 1'b0;
    case (state)
      SEEK: src_rd = head_stale;
      STREAM: begin
        src_rd    = head_stale | (head_match & disp_rd);
        emit_fill = disp_rd & ~head_match;
        if (head_match) begin
          o_data = src_data;
        end
      end
      HOLD: emit_fill = disp_rd;
      default: ;
    endcase
  end

  // Line FSM, word counter and saturating event counters
  always_ff @(posedge i_clk_74M) begin
    if (i_rst) begin
      state        <= IDLE;
      target       <= '0;
      word_cnt     <= '0;
      rd_seen      <= 1'b0;
      underrun_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      if (emit_fill && (underrun_cnt != '1)) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
      if (src_rd && head_stale && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      case (state)
        IDLE: begin
          if (line_start) begin
            state    <= SEEK;
            target   <= 11'(i_vcnt - VSTART_V);
            word_cnt <= '0;
            rd_seen  <= 1'b0;
          end
        end
        SEEK: begin
          if (head_match) begin
            state <= STREAM;
          end else if (head_ahead) begin
            state <= HOLD;
          end else if (src_empty && (i_hcnt == HSTART_H)) begin
            state <= STREAM;
          end
        end
        STREAM, HOLD: begin
          if (disp_rd) begin
            word_cnt <= word_cnt + 11'd1;
          end
          rd_seen <= rd_seen | disp_rd;
          if (line_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_state        = state;
  assign o_underrun_cnt = underrun_cnt;
  assign o_drop_cnt     = drop_cnt;

endmodule
